cr16_run_ctrl: RTL and testbench

- Parametrised run/debug controller for the CR16 processor on the board top level.
- Replaces fixed warm-up and max-PC logic with a state machine providing:
  - programmable BRAM warm-up
  - free-run and single-step modes
  - a PC breakpoint
  - an enabled-cycle counter
  - a selectable 7-segment display source
- Drives the CR16 I_ENABLE; the CR16 clock runs ungated.

---
 rtl/cr16_run_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_cr16_run_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/cr16_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : cr16_run_ctrl
// Purpose  : Run/debug controller for the CR16 core. It provides a BRAM
//            warm-up delay after reset, free-run and single-step execution,
//            a PC breakpoint, a permanent halt above a maximum PC, a
//            saturating enabled-cycle counter and the 7-segment display mux.
//            The CR16 clock runs ungated; only I_ENABLE is controlled.
// Ports    : I_CLK, I_NRESET        - clock, asynchronous active-low reset
//            I_STEP_MODE            - 1 = single-step, 0 = free-run
//            I_STEP, I_RUN          - level inputs, rising edge acts
//            I_BREAK_EN/ADDR        - PC breakpoint
//            I_DISPLAY_SEL          - 0 = PC/result (mem B in HALT), 1 = count
//            I_PC, I_RESULT_BUS     - CR16 status
//            I_MEM_DATA_B           - BRAM port B read data
//            O_CR16_ENABLE          - CR16 enable
//            O_STATE                - WARMUP=0 RUN=1 PAUSE=2 STEP=3 HALT=4
//            O_HALTED               - high in HALT
//            O_CYCLE_COUNT          - cycles with O_CR16_ENABLE high
//            O_DISPLAY_BITS         - nibbles for the hex digit drivers
// Revision : 1.0 - initial release
// ============================================================================
module cr16_run_ctrl #(
    parameter int P_PC_WIDTH        = 16,
    parameter int P_DATA_WIDTH      = 16,
    parameter int P_NUM_DIGITS      = 6,
    parameter int P_COLD_CLK_CYCLES = 2,
    parameter int P_MAX_PC          = 32,
    parameter int P_COUNT_WIDTH     = 24
) (
    input  logic                      I_CLK,
    input  logic                      I_NRESET,
    input  logic                      I_STEP_MODE,
    input  logic                      I_STEP,
    input  logic                      I_RUN,
    input  logic                      I_BREAK_EN,
    input  logic [P_PC_WIDTH-1:0]     I_BREAK_ADDR,
    input  logic                      I_DISPLAY_SEL,
    input  logic [P_PC_WIDTH-1:0]     I_PC,
    input  logic [P_DATA_WIDTH-1:0]   I_RESULT_BUS,
    input  logic [P_DATA_WIDTH-1:0]   I_MEM_DATA_B,
    output logic                      O_CR16_ENABLE,
    output logic [2:0]                O_STATE,
    output logic                      O_HALTED,
    output logic [P_COUNT_WIDTH-1:0]  O_CYCLE_COUNT,
    output logic [4*P_NUM_DIGITS-1:0] O_DISPLAY_BITS
);

    localparam int DISP_W = 4 * P_NUM_DIGITS;
    localparam int PC_SHOWN_W = DISP_W - P_DATA_WIDTH;
    localparam int WARM_W = (P_COLD_CLK_CYCLES > 1) ? $clog2(P_COLD_CLK_CYCLES) : 1;

    localparam logic [WARM_W-1:0]        WARM_LAST = WARM_W'(P_COLD_CLK_CYCLES - 1);
    localparam logic [WARM_W-1:0]        WARM_ONE  = WARM_W'(1);
    localparam logic [P_PC_WIDTH-1:0]    MAX_PC    = P_PC_WIDTH'(P_MAX_PC);
    localparam logic [P_COUNT_WIDTH-1:0] CNT_ONE   = P_COUNT_WIDTH'(1);
    localparam logic [P_COUNT_WIDTH-1:0] CNT_MAX   = '1;

    typedef enum logic [2:0] {
        ST_WARMUP = 3'd0,
        ST_RUN    = 3'd1,
        ST_PAUSE  = 3'd2,
        ST_STEP   = 3'd3,
        ST_HALT   = 3'd4
    } state_t;

    state_t                   state_q, state_d;
    logic [WARM_W-1:0]        warm_q, warm_d;
    logic [P_COUNT_WIDTH-1:0] cnt_q;
    logic                     brk_mask_q, brk_mask_d;
    logic                     step_prev_q, run_prev_q;

    logic halt_max;
    logic brk;
    logic step_pulse;
    logic run_pulse;
    logic enable;

    assign halt_max   = (I_PC > MAX_PC);
    // The mask lets execution leave the breakpoint PC after a resume.
    assign brk        = I_BREAK_EN & (I_PC == I_BREAK_ADDR) & ~brk_mask_q;
    assign step_pulse = I_STEP & ~step_prev_q;
    assign run_pulse  = I_RUN & ~run_prev_q;

    always_ff @(posedge I_CLK or negedge I_NRESET) begin
        if (!I_NRESET) begin
            state_q     <= ST_WARMUP;
            warm_q      <= '0;
            brk_mask_q  <= 1'b0;
            step_prev_q <= 1'b0;
            run_prev_q  <= 1'b0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            warm_q      <= warm_d;
            brk_mask_q  <= brk_mask_d;
            step_prev_q <= I_STEP;
            run_prev_q  <= I_RUN;
            if (enable && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_ONE;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        warm_d     = warm_q;
        brk_mask_d = brk_mask_q;
        enable     = 1'b0;
        case (state_q)
            ST_WARMUP: begin
                if (warm_q == WARM_LAST) begin
                    state_d = I_STEP_MODE ? ST_PAUSE : ST_RUN;
                end else begin
                    warm_d = warm_q + WARM_ONE;
                end
            end
            ST_RUN: begin
                // Enable drops in the very cycle the stop condition is seen,
                // so the offending instruction is never executed.
                enable     = ~halt_max & ~brk;
                brk_mask_d = 1'b0;
                if (halt_max) begin
                    state_d = ST_HALT;
                end else if (brk || I_STEP_MODE) begin
                    state_d = ST_PAUSE;
                end
            end
            ST_PAUSE: begin
                if (halt_max) begin
                    state_d = ST_HALT;
                end else if (step_pulse) begin
                    state_d = ST_STEP;
                end else if (run_pulse && !I_STEP_MODE) begin
                    state_d    = ST_RUN;
                    brk_mask_d = 1'b1;
                end
            end
            ST_STEP: begin
                enable  = ~halt_max;
                state_d = halt_max ? ST_HALT : ST_PAUSE;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: begin
                state_d = ST_WARMUP;
            end
        endcase
    end

    assign O_CR16_ENABLE = enable;
    assign O_STATE       = state_q;
    assign O_HALTED      = (state_q == ST_HALT);
    assign O_CYCLE_COUNT = cnt_q;

    // Display sources, each fitted to the display width.
    logic [DISP_W-1:0] disp_pc_res;
    logic [DISP_W-1:0] disp_mem;
    logic [DISP_W-1:0] disp_cnt;

    generate
        if (PC_SHOWN_W == 0) begin : g_pr_res_only
            assign disp_pc_res = I_RESULT_BUS;
        end else if (PC_SHOWN_W <= P_PC_WIDTH) begin : g_pr_pc_trunc
            assign disp_pc_res = {I_PC[PC_SHOWN_W-1:0], I_RESULT_BUS};
        end else begin : g_pr_pc_ext
            assign disp_pc_res = {{(PC_SHOWN_W-P_PC_WIDTH){1'b0}}, I_PC, I_RESULT_BUS};
        end

        if (DISP_W == P_DATA_WIDTH) begin : g_mem_exact
            assign disp_mem = I_MEM_DATA_B;
        end else begin : g_mem_ext
            assign disp_mem = {{(DISP_W-P_DATA_WIDTH){1'b0}}, I_MEM_DATA_B};
        end

        if (DISP_W <= P_COUNT_WIDTH) begin : g_cnt_trunc
            assign disp_cnt = cnt_q[DISP_W-1:0];
        end else begin : g_cnt_ext
            assign disp_cnt = {{(DISP_W-P_COUNT_WIDTH){1'b0}}, cnt_q};
        end
    endgenerate

    always_comb begin
        O_DISPLAY_BITS = disp_pc_res;
        if (I_DISPLAY_SEL) begin
            O_DISPLAY_BITS = disp_cnt;
        end else if (state_q == ST_HALT) begin
            O_DISPLAY_BITS = disp_mem;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cr16_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_cr16_run_ctrl
// Purpose  : Self-checking bench for cr16_run_ctrl. A cycle-level reference
//            model checks every output on each falling edge; directed
//            scenarios add literal expectations. A tiny CPU stand-in advances
//            the PC on each enabled cycle (optionally looping 20 -> 12).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cr16_run_ctrl;

    localparam int COLD = 2;
    localparam int MAXPC = 32;
    localparam longint CNT_SAT = 64'hFF_FFFF;

    logic        clk;
    logic        nrst;
    logic        step_mode, step, run, brk_en, disp_sel;
    logic [15:0] brk_addr, pc, result, mem_b;
    logic        en;
    logic [2:0]  state;
    logic        halted;
    logic [23:0] cycle_count;
    logic [23:0] disp;

    cr16_run_ctrl dut (
        .I_CLK         (clk),
        .I_NRESET      (nrst),
        .I_STEP_MODE   (step_mode),
        .I_STEP        (step),
        .I_RUN         (run),
        .I_BREAK_EN    (brk_en),
        .I_BREAK_ADDR  (brk_addr),
        .I_DISPLAY_SEL (disp_sel),
        .I_PC          (pc),
        .I_RESULT_BUS  (result),
        .I_MEM_DATA_B  (mem_b),
        .O_CR16_ENABLE (en),
        .O_STATE       (state),
        .O_HALTED      (halted),
        .O_CYCLE_COUNT (cycle_count),
        .O_DISPLAY_BITS(disp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: mode names follow the externally visible state code.
    // ------------------------------------------------------------------
    localparam int M_WARM = 0, M_RUN = 1, M_PAUSE = 2, M_STEP = 3, M_HALT = 4;
    int     m_mode;
    int     m_warm;
    longint m_cnt;
    bit     m_mask, m_pstep, m_prun;

    always @(negedge clk) begin
        bit over, hit, sp, rp, e_en;
        longint e_disp;
        if (!nrst) begin
            m_mode = M_WARM; m_warm = 0; m_cnt = 0;
            m_mask = 0; m_pstep = 0; m_prun = 0;
            check("rst_en", en, 0);
            check("rst_state", state, M_WARM);
            check("rst_halted", halted, 0);
            check("rst_count", cycle_count, 0);
        end else begin
            over = (pc > MAXPC);
            hit  = brk_en && (pc == brk_addr) && !m_mask;
            sp   = step && !m_pstep;
            rp   = run && !m_prun;
            e_en = ((m_mode == M_RUN) && !over && !hit) || ((m_mode == M_STEP) && !over);
            if (disp_sel)              e_disp = m_cnt % (64'd1 << 24);
            else if (m_mode == M_HALT) e_disp = mem_b;
            else                       e_disp = (pc % 256) * 65536 + result;
            check("model_en", en, e_en);
            check("model_state", state, m_mode);
            check("model_halted", halted, m_mode == M_HALT);
            check("model_count", cycle_count, m_cnt);
            check("model_disp", disp, e_disp);
            // advance the model to the next cycle
            if (e_en && m_cnt < CNT_SAT) m_cnt = m_cnt + 1;
            case (m_mode)
                M_WARM: begin
                    if (m_warm == COLD - 1) m_mode = step_mode ? M_PAUSE : M_RUN;
                    else m_warm = m_warm + 1;
                end
                M_RUN: begin
                    m_mask = 0;
                    if (over) m_mode = M_HALT;
                    else if (hit || step_mode) m_mode = M_PAUSE;
                end
                M_PAUSE: begin
                    if (over) m_mode = M_HALT;
                    else if (sp) m_mode = M_STEP;
                    else if (rp && !step_mode) begin
                        m_mode = M_RUN;
                        m_mask = 1;
                    end
                end
                M_STEP: m_mode = over ? M_HALT : M_PAUSE;
                default: m_mode = M_HALT;
            endcase
            m_pstep = step;
            m_prun  = run;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    bit loop_en;

    // One cycle of the CPU stand-in: PC advances after each enabled cycle.
    task automatic run_cpu(input int n);
        for (int i = 0; i < n; i++) begin
            logic e;
            @(negedge clk);
            e = en;
            @(posedge clk);
            #1;
            if (e) pc = (loop_en && pc == 16'd20) ? 16'd12 : pc + 16'd1;
        end
    endtask

    task automatic reset_dut();
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        nrst = 1'b1;
    endtask

    initial begin
        nrst = 1'b0; step_mode = 0; step = 0; run = 0; brk_en = 0;
        brk_addr = 16'h0010; disp_sel = 0; pc = 0; result = 16'h1234;
        mem_b = 16'h2AF8; loop_en = 0;

        // ---- reset release and free-run to the PC limit ----
        #2;
        check("por_en", en, 0);
        check("por_state", state, 0);
        reset_dut();
        @(negedge clk); check("warm0_en", en, 0); check("warm0_state", state, 0);
        @(negedge clk); check("warm1_en", en, 0); check("warm1_state", state, 0);
        @(negedge clk); check("run0_en", en, 1); check("run0_state", state, 1);
        @(posedge clk); #1; pc = pc + 16'd1;
        run_cpu(40);
        check("halt_pc", pc, 33);
        check("halt_state", state, 4);
        check("halt_flag", halted, 1);
        check("halt_count", cycle_count, 33);
        check("halt_disp_mem", disp, 24'h002AF8);
        disp_sel = 1; #1;
        check("halt_disp_cnt", disp, 24'h000021);
        disp_sel = 0;

        // ---- breakpoint, masked resume, second hit, reset in RUN ----
        pc = 0; brk_en = 1; loop_en = 1;
        reset_dut();
        run_cpu(25);
        check("brk1_pc", pc, 16);
        check("brk1_state", state, 2);
        check("brk1_en", en, 0);
        check("brk1_count", cycle_count, 16);
        run = 1;
        run_cpu(15);
        check("brk2_pc", pc, 16);
        check("brk2_state", state, 2);
        check("brk2_count", cycle_count, 25);
        run = 0;
        run_cpu(1);
        run = 1;
        run_cpu(3);
        check("resume_state", state, 1);
        check("resume_pc", pc, 18);
        #2 nrst = 1'b0;
        #1;
        check("async_rst_en", en, 0);
        check("async_rst_state", state, 0);
        check("async_rst_count", cycle_count, 0);
        check("async_rst_halted", halted, 0);
        run = 0; brk_en = 0; loop_en = 0;

        // ---- single-step mode ----
        pc = 0; step_mode = 1;
        reset_dut();
        run_cpu(4);
        check("step_idle_state", state, 2);
        for (int k = 0; k < 3; k++) begin
            step = 1; run_cpu(4);
            step = 0; run_cpu(3);
        end
        check("step3_count", cycle_count, 3);
        check("step3_pc", pc, 3);
        check("step3_state", state, 2);
        step_mode = 0;
        run_cpu(2);
        step = 1; run = 1;
        run_cpu(5);
        check("step_run_count", cycle_count, 4);
        check("step_run_state", state, 2);
        pc = 16'd40;
        run_cpu(2);
        check("pause_halt_state", state, 4);
        step = 0; run = 0;

        // ---- display sources during RUN ----
        pc = 0; result = 16'hBEEF;
        reset_dut();
        run_cpu(7);
        @(negedge clk);
        check("disp_pc_res", disp, 24'h05BEEF);
        #1 disp_sel = 1;
        #1 check("disp_count5", disp, 24'h000005);
        disp_sel = 0;
        run_cpu(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
